pipeline_ctrl: RTL and testbench

Hazard and stall controller for the five-stage pipeline. Drives per-register hold and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Inserts load-use stalls, flushes on taken branches, and sequences variable-latency data-memory accesses. While MEM is waiting, MEM/WB receives bubbles (write-enable forced to 0), so the register file never sees a stale writeback.

---
 rtl/pipeline_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, flush and memory-wait controller for the five-stage pipeline
module pipeline_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rs_re,
    input  logic [4:0]       id_rs_addr,
    input  logic             id_rt_re,
    input  logic [4:0]       id_rt_addr,
    input  logic             ex_is_load,
    input  logic             ex_we,
    input  logic [4:0]       ex_wd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             dmem_en,
    output logic [4:0]       stall,
    output logic             flush_ifid,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    // wait_cnt only has to reach MAX_WAIT-1 before the timeout decision
    localparam int                WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    // hold patterns: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB
    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_LU   = 5'b00011;
    localparam logic [4:0] STALL_MEM  = 5'b01111;
    localparam logic [4:0] STALL_ALL  = 5'b11111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic       rs_hit;
    logic       rt_hit;
    logic       load_use;
    logic [4:0] haz_stall;
    logic       haz_flush;
    logic       haz_bubble;

    logic [4:0] stall_c;
    logic       flush_c;
    logic       idex_c;
    logic       memwb_c;
    logic       dmem_c;

    // load-use: ID needs a register that the load in EX has not produced yet
    always_comb begin
        rs_hit   = id_rs_re & (id_rs_addr == ex_wd);
        rt_hit   = id_rt_re & (id_rt_addr == ex_wd);
        load_use = ex_is_load & ex_we & (ex_wd != 5'd0) & (rs_hit | rt_hit);
    end

    // front-end hazard resolution; a taken branch squashes the dependent instruction, so it wins
    always_comb begin
        haz_stall  = STALL_NONE;
        haz_flush  = 1'b0;
        haz_bubble = 1'b0;
        if (ex_branch_taken) begin
            haz_flush  = 1'b1;
            haz_bubble = 1'b1;
        end else if (load_use) begin
            haz_stall  = STALL_LU;
            haz_bubble = 1'b1;
        end
    end

    // next-state and pipeline controls; front-end hazards wait in place until memory releases
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_c       = STALL_NONE;
        flush_c       = 1'b0;
        idex_c        = 1'b0;
        memwb_c       = 1'b0;
        dmem_c        = 1'b0;

        case (state_q)
            ST_RUN: begin
                dmem_c = mem_req;
                if (mem_req && !dmem_ready) begin
                    stall_c    = STALL_MEM;
                    memwb_c    = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    stall_c = haz_stall;
                    flush_c = haz_flush;
                    idex_c  = haz_bubble;
                end
            end

            ST_MEM_WAIT: begin
                dmem_c = 1'b1;
                if (dmem_ready) begin
                    stall_c    = haz_stall;
                    flush_c    = haz_flush;
                    idex_c     = haz_bubble;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    stall_c = STALL_MEM;
                    memwb_c = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d       = ST_TIMEOUT;
                        mem_timeout_d = 1'b1;
                        wait_cnt_d    = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end

            ST_TIMEOUT: begin
                // freeze the whole pipeline; only reset leaves this state
                stall_c       = STALL_ALL;
                memwb_c       = 1'b1;
                mem_timeout_d = 1'b1;
            end

            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        // during reset every pipeline register is loaded with a NOP and memory is idle
        if (rst) begin
            stall_c = STALL_NONE;
            flush_c = 1'b1;
            idex_c  = 1'b1;
            memwb_c = 1'b1;
            dmem_c  = 1'b0;
        end
    end

    // saturating count of cycles in which any pipeline register was held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall_c != STALL_NONE) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // state registers with synchronous reset; a pending memory request is dropped on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // output drive
    always_comb begin
        dmem_en      = dmem_c;
        stall        = stall_c;
        flush_ifid   = flush_c;
        idex_bubble  = idex_c;
        memwb_bubble = memwb_c;
        mem_timeout  = mem_timeout_q;
        stall_cnt    = stall_cnt_q;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized checks of pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_rs_re = 1'b0;
    logic [4:0]       id_rs_addr = 5'd0;
    logic             id_rt_re = 1'b0;
    logic [4:0]       id_rt_addr = 5'd0;
    logic             ex_is_load = 1'b0;
    logic             ex_we = 1'b0;
    logic [4:0]       ex_wd = 5'd0;
    logic             ex_branch_taken = 1'b0;
    logic             mem_req = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             dmem_en;
    logic [4:0]       stall;
    logic             flush_ifid;
    logic             idex_bubble;
    logic             memwb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs_re(id_rs_re), .id_rs_addr(id_rs_addr),
        .id_rt_re(id_rt_re), .id_rt_addr(id_rt_addr),
        .ex_is_load(ex_is_load), .ex_we(ex_we), .ex_wd(ex_wd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .dmem_en(dmem_en), .stall(stall), .flush_ifid(flush_ifid),
        .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: is a memory access outstanding, how many not-ready cycles so far, did it time out
    bit   m_waiting   = 1'b0;
    bit   m_timed_out = 1'b0;
    int   m_waited    = 0;
    int   m_cnt       = 0;
    logic [4:0] e_stall;
    logic e_flush, e_idex, e_memwb, e_dmem;

    function automatic bit model_lu();
        return ex_is_load && ex_we && (ex_wd != 5'd0) &&
               ((id_rs_re && id_rs_addr == ex_wd) || (id_rt_re && id_rt_addr == ex_wd));
    endfunction

    task automatic model_eval();
        bit blocked;
        e_stall = 5'd0; e_flush = 0; e_idex = 0; e_memwb = 0; e_dmem = 0;
        if (rst) begin
            e_flush = 1; e_idex = 1; e_memwb = 1;
        end else if (m_timed_out) begin
            e_stall = 5'h1F;
        end else begin
            blocked = m_waiting ? !dmem_ready : (mem_req && !dmem_ready);
            e_dmem  = m_waiting ? 1'b1 : mem_req;
            if (blocked) begin
                e_stall = 5'h0F; e_memwb = 1;
            end else if (ex_branch_taken) begin
                e_flush = 1; e_idex = 1;
            end else if (model_lu()) begin
                e_stall = 5'h03; e_idex = 1;
            end
        end
    endtask

    task automatic model_advance();
        model_eval();
        if (rst) begin
            m_waiting = 0; m_timed_out = 0; m_waited = 0; m_cnt = 0;
        end else begin
            if (e_stall != 5'd0 && m_cnt < CNT_MAX) m_cnt++;
            if (m_timed_out) begin
            end else if (m_waiting) begin
                if (dmem_ready) m_waiting = 0;
                else begin
                    m_waited++;
                    if (m_waited == MAX_WAIT) begin m_timed_out = 1; m_waiting = 0; end
                end
            end else if (mem_req && !dmem_ready) begin
                m_waiting = 1; m_waited = 0;
            end
        end
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs_re = 0; id_rs_addr = 0; id_rt_re = 0; id_rt_addr = 0;
        ex_is_load = 0; ex_we = 0; ex_wd = 0; ex_branch_taken = 0;
        mem_req = 0; dmem_ready = 0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_is_load = 1; ex_we = 1; ex_wd = r; id_rs_re = 1; id_rs_addr = r;
    endtask

    task automatic do_reset();
        rst = 1; set_idle();
        @(negedge clk);
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        set_idle(); mem_req = 1; ex_branch_taken = 1; set_lu(5'd3);
        @(negedge clk);
        n_cmp++; if (stall !== 5'b00000) begin n_fail++; $display("FAIL reset_stall: got %b exp 00000", stall); end
        n_cmp++; if ({flush_ifid, idex_bubble, memwb_bubble, dmem_en} !== 4'b1110) begin
            n_fail++; $display("FAIL reset_forced: got %b exp 1110", {flush_ifid, idex_bubble, memwb_bubble, dmem_en}); end
        tick();
        rst = 0; set_idle();
        @(negedge clk);
        n_cmp++; if ({mem_timeout, stall_cnt, stall} !== '0) begin
            n_fail++; $display("FAIL reset_regs: timeout=%b cnt=%0d stall=%b exp all 0", mem_timeout, stall_cnt, stall); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_idle(); set_lu(5'd5);
        @(negedge clk);
        n_cmp++; if ({stall, idex_bubble, flush_ifid} !== {5'b00011, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL lu_rs: stall=%b idex=%b flush=%b exp 00011 1 0", stall, idex_bubble, flush_ifid); end
        tick();
        set_idle(); mem_req = 1; dmem_ready = 1;
        @(negedge clk);
        n_cmp++; if ({stall, idex_bubble, dmem_en} !== {5'b00000, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL lu_next_zero_wait: stall=%b idex=%b dmem=%b exp 00000 0 1", stall, idex_bubble, dmem_en); end
        tick();
        set_idle(); set_lu(5'd0);
        @(negedge clk);
        n_cmp++; if ({stall, idex_bubble} !== 6'b000000) begin
            n_fail++; $display("FAIL lu_r0: stall=%b idex=%b exp 00000 0", stall, idex_bubble); end
        tick();
        set_idle(); ex_is_load = 1; ex_we = 1; ex_wd = 5'd7; id_rt_re = 1; id_rt_addr = 5'd7;
        @(negedge clk);
        n_cmp++; if ({stall, idex_bubble} !== {5'b00011, 1'b1}) begin
            n_fail++; $display("FAIL lu_rt: stall=%b idex=%b exp 00011 1", stall, idex_bubble); end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_idle(); mem_req = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if ({stall, memwb_bubble, dmem_en} !== {5'b01111, 1'b1, 1'b1}) begin
                n_fail++; $display("FAIL mem_wait_c%0d: stall=%b memwb=%b dmem=%b exp 01111 1 1", c, stall, memwb_bubble, dmem_en); end
            tick();
        end
        dmem_ready = 1;
        @(negedge clk);
        n_cmp++; if ({stall, memwb_bubble, dmem_en} !== {5'b00000, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL mem_release: stall=%b memwb=%b dmem=%b exp 00000 0 1", stall, memwb_bubble, dmem_en); end
        tick();
        set_idle();
        @(negedge clk);
        n_cmp++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL mem_stall_cnt: got %0d exp 2", stall_cnt); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        set_idle(); mem_req = 1;
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            if (t <= 4) begin
                n_cmp++; if ({stall, mem_timeout} !== {5'b01111, 1'b0}) begin
                    n_fail++; $display("FAIL timeout_T%0d: stall=%b timeout=%b exp 01111 0", t, stall, mem_timeout); end
            end else begin
                n_cmp++; if ({stall, mem_timeout, dmem_en} !== {5'b11111, 1'b1, 1'b0}) begin
                    n_fail++; $display("FAIL timeout_T5: stall=%b timeout=%b dmem=%b exp 11111 1 0", stall, mem_timeout, dmem_en); end
            end
            tick();
        end
        dmem_ready = 1;
        @(negedge clk);
        n_cmp++; if ({stall, mem_timeout} !== {5'b11111, 1'b1}) begin
            n_fail++; $display("FAIL timeout_sticky: stall=%b timeout=%b exp 11111 1", stall, mem_timeout); end
        tick();
        do_reset();
        set_idle(); mem_req = 1;
        for (int t = 0; t <= 4; t++) begin
            dmem_ready = (t == 4);
            @(negedge clk);
            if (t == 4) begin
                n_cmp++; if (stall !== 5'b00000) begin n_fail++; $display("FAIL late_ready_T4: stall=%b exp 00000", stall); end
            end
            tick();
        end
        set_idle();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            n_cmp++; if ({stall, mem_timeout} !== 6'b000000) begin
                n_fail++; $display("FAIL late_ready_run%0d: stall=%b timeout=%b exp 00000 0", t, stall, mem_timeout); end
            tick();
        end
    endtask

    task automatic test_branch_lu();
        do_reset();
        set_idle(); set_lu(5'd9); ex_branch_taken = 1;
        @(negedge clk);
        n_cmp++; if ({flush_ifid, idex_bubble, stall} !== {1'b1, 1'b1, 5'b00000}) begin
            n_fail++; $display("FAIL branch_over_lu: flush=%b idex=%b stall=%b exp 1 1 00000", flush_ifid, idex_bubble, stall); end
        tick();
    endtask

    task automatic test_branch_in_wait();
        do_reset();
        set_idle(); mem_req = 1; ex_branch_taken = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if ({flush_ifid, idex_bubble, stall} !== {1'b0, 1'b0, 5'b01111}) begin
                n_fail++; $display("FAIL branch_held_c%0d: flush=%b idex=%b stall=%b exp 0 0 01111", c, flush_ifid, idex_bubble, stall); end
            tick();
        end
        dmem_ready = 1;
        @(negedge clk);
        n_cmp++; if ({flush_ifid, idex_bubble, stall} !== {1'b1, 1'b1, 5'b00000}) begin
            n_fail++; $display("FAIL branch_release: flush=%b idex=%b stall=%b exp 1 1 00000", flush_ifid, idex_bubble, stall); end
        tick();
        set_idle(); mem_req = 1; set_lu(5'd4);
        @(negedge clk);
        n_cmp++; if ({idex_bubble, stall} !== {1'b0, 5'b01111}) begin
            n_fail++; $display("FAIL lu_held: idex=%b stall=%b exp 0 01111", idex_bubble, stall); end
        tick();
        dmem_ready = 1;
        @(negedge clk);
        n_cmp++; if ({idex_bubble, stall} !== {1'b1, 5'b00011}) begin
            n_fail++; $display("FAIL lu_release: idex=%b stall=%b exp 1 00011", idex_bubble, stall); end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        set_idle(); set_lu(5'd12);
        for (int c = 0; c < 20; c++) tick();
        set_idle();
        @(negedge clk);
        n_cmp++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL stall_cnt_sat: got %0d exp 15", stall_cnt); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_idle(); set_lu(5'd2);
        for (int c = 0; c < 3; c++) tick();
        set_idle(); mem_req = 1;
        tick(); tick();
        rst = 1;
        @(negedge clk);
        n_cmp++; if ({stall, dmem_en, memwb_bubble} !== {5'b00000, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rst_mid_wait_forced: stall=%b dmem=%b memwb=%b exp 00000 0 1", stall, dmem_en, memwb_bubble); end
        tick();
        rst = 0; set_idle();
        @(negedge clk);
        n_cmp++; if ({stall, dmem_en, mem_timeout, stall_cnt} !== '0) begin
            n_fail++; $display("FAIL rst_mid_wait_cleared: stall=%b dmem=%b timeout=%b cnt=%0d exp all 0", stall, dmem_en, mem_timeout, stall_cnt); end
        tick();
        mem_req = 1; dmem_ready = 1;
        @(negedge clk);
        n_cmp++; if ({stall, dmem_en} !== {5'b00000, 1'b1}) begin
            n_fail++; $display("FAIL rst_mid_wait_run: stall=%b dmem=%b exp 00000 1", stall, dmem_en); end
        tick();
    endtask

    task automatic test_random();
        logic [14:0] got, exp, mask;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(63) == 0);
            id_rs_re        = $urandom_range(1);
            id_rs_addr      = 5'($urandom_range(3));
            id_rt_re        = $urandom_range(1);
            id_rt_addr      = 5'($urandom_range(3));
            ex_is_load      = $urandom_range(1);
            ex_we           = ($urandom_range(3) != 0);
            ex_wd           = 5'($urandom_range(3));
            ex_branch_taken = ($urandom_range(5) == 0);
            mem_req         = ($urandom_range(2) == 0);
            dmem_ready      = ($urandom_range(9) < 6);
            @(negedge clk);
            model_eval();
            got  = {stall, flush_ifid, idex_bubble, memwb_bubble, dmem_en, mem_timeout, stall_cnt};
            exp  = {e_stall, e_flush, e_idex, e_memwb, e_dmem, m_timed_out, CNT_W'(m_cnt)};
            // flush/bubble values are not defined while frozen in timeout
            mask = (m_timed_out && !rst) ? 15'b11111_000_1_1_1111 : 15'h7FFF;
            n_cmp++;
            if ((got & mask) !== (exp & mask)) begin
                n_fail++;
                $display("FAIL random_c%0d: got stall=%b fl=%b idex=%b mwb=%b den=%b to=%b cnt=%0d exp stall=%b fl=%b idex=%b mwb=%b den=%b to=%b cnt=%0d",
                         c, stall, flush_ifid, idex_bubble, memwb_bubble, dmem_en, mem_timeout, stall_cnt,
                         e_stall, e_flush, e_idex, e_memwb, e_dmem, m_timed_out, m_cnt);
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_branch_lu();
        test_branch_in_wait();
        test_saturate();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
